cache_axi_burst_if: RTL and testbench
=====================================

CACHE_AXI_BURST_IF -- requirements
Module: cache_axi_burst_if
Interface
REQ-001 LINE_WORDS, default 4, words (32-bit) per cache line; legal 1,2,4,8,16; sets AXI burst length.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 rd_req  input  1  cache requests a line refill.
REQ-005 rd_addr  input  32  refill line address, sampled when rd_req accepted.
REQ-006 rd_rdy  output  1  read channel idle; rd_req accepted when rd_req&rd_rdy.
REQ-007 ret_valid  output  1  one refill word valid this cycle.
REQ-008 ret_last  output  1  final refill word.
REQ-009 ret_data  output  32  refill word.
REQ-010 wr_req  input  1  cache requests a line writeback.
REQ-011 wr_addr  input  32  writeback line address, sampled on accept.
REQ-012 wr_data  input  LINE_WORDS*32  writeback line, word 0 in bits [31:0], sampled on accept.
REQ-013 wr_rdy  output  1  write channel idle; wr_req accepted when wr_req&wr_rdy.
REQ-014 arvalid  output  1  AXI read-address valid.
REQ-015 arready  input  1  AXI read-address ready.
REQ-016 araddr  output  32  AXI read address, line-aligned.
REQ-017 arlen  output  8  AXI read burst length, LINE_WORDS-1.
REQ-018 rvalid  input  1  AXI read-data valid.
REQ-019 rdata  input  32  AXI read data.
REQ-020 rlast  input  1  AXI last read beat.
REQ-021 rready  output  1  AXI read-data ready.
REQ-022 awvalid  output  1  AXI write-address valid.
REQ-023 awready  input  1  AXI write-address ready.
REQ-024 awaddr  output  32  AXI write address, line-aligned.
REQ-025 awlen  output  8  AXI write burst length, LINE_WORDS-1.
REQ-026 wvalid  output  1  AXI write-data valid.
REQ-027 wready  input  1  AXI write-data ready.
REQ-028 wdata  output  32  AXI write data beat.
REQ-029 wlast  output  1  AXI last write beat.
REQ-030 bvalid  input  1  AXI write response valid.
REQ-031 bresp  input  2  AXI write response.
REQ-032 bready  output  1  AXI write response ready.
Function
REQ-033 Read FSM R_IDLE->R_ADDR on rd_req&rd_rdy; R_ADDR->R_DATA on arvalid&arready; R_DATA->R_IDLE on rvalid&rlast; rd_rdy=1 only in R_IDLE.
REQ-034 arvalid=1 exactly in R_ADDR, araddr/arlen held stable until handshake; rready=1 in R_DATA; ret_valid=rvalid&rready, ret_data=rdata, ret_last=rlast, zero added latency.
REQ-035 Write FSM W_IDLE->W_AW on accept (line latched same edge); W_AW->W_DATA on awvalid&awready; W_DATA->W_RESP on wvalid&wready&wlast; W_RESP->W_IDLE on bvalid with bresp[1]=0; wr_rdy=1 only in W_IDLE.
REQ-036 Beat counter width clog2(LINE_WORDS) (min 1), zeroed entering W_DATA, +1 per wvalid&wready; wdata=latched word[counter]; wlast=(counter==LINE_WORDS-1); LINE_WORDS=1 gives wlast=1 on sole beat.
REQ-037 wvalid=1 throughout W_DATA; wdata held while wready=0; bready=1 only in W_RESP.
REQ-038 bresp[1]=1 (SLVERR/DECERR) in W_RESP: return to W_AW and replay whole burst from latched line; no retry limit.
REQ-039 Read and write FSMs independent; simultaneous rd_req and wr_req both accepted same cycle; AXI IDs fixed 0, size 4 bytes, burst INCR (outside this block).
REQ-040 Addresses: araddr/awaddr = latched address with low clog2(LINE_WORDS*4) bits cleared.
Reset
REQ-041 resetn low (any cycle, mid-burst included): both FSMs to IDLE, counter 0, arvalid=awvalid=wvalid=rready=bready=0, rd_rdy=wr_rdy=1, latched line/addresses 0; in-flight burst abandoned.
REQ-042 After resetn rises, first accept possible on the first rising edge.
Configuration
REQ-043 RAW_HAZARD_CHECK_EN defined: rd_req with line address equal to write-FSM latched address while write FSM not W_IDLE is held off (rd_rdy=0) until write FSM returns to W_IDLE; undefined: no check, rd_rdy depends only on read FSM.
Verification
REQ-044 LINE_WORDS=4, rd_req addr 0x1C00_0014, arready after 2 cycles, 4 beats rlast on 4th -> araddr 0x1C00_0010, arlen 3, ret_valid x4, ret_last on beat 4, rd_rdy back next cycle.
REQ-045 wr_req addr 0x0000_0100, data {D3,D2,D1,D0}, wready toggling 1/0 -> wdata D0..D3 in order, held during wready=0, wlast only with D3, bready until bvalid.
REQ-046 bresp=2'b10 on first response -> awvalid reasserts, D0..D3 replayed, completes on bresp=2'b00.
REQ-047 rd_req and wr_req same cycle, same address 0x80 -> with RAW_HAZARD_CHECK_EN arvalid only after write bvalid; without, arvalid next cycle.
REQ-048 resetn pulsed low during write beat 2 -> outputs at reset values asynchronously; new wr_req after release starts at D0; repeat with LINE_WORDS=1 and 16.

Source files
------------

// File: rtl/cache_axi_burst_if.sv
// Cache line refill/writeback bridge onto AXI INCR bursts, one line per burst.
// Optional RAW_HAZARD_CHECK_EN holds off refills of a line that is still being written back.
module cache_axi_burst_if #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    // cache refill side
    input  logic                       rd_req,
    input  logic [31:0]                rd_addr,
    output logic                       rd_rdy,
    output logic                       ret_valid,
    output logic                       ret_last,
    output logic [31:0]                ret_data,
    // cache writeback side
    input  logic                       wr_req,
    input  logic [31:0]                wr_addr,
    input  logic [LINE_WORDS*32-1:0]   wr_data,
    output logic                       wr_rdy,
    // AXI read address
    output logic                       arvalid,
    input  logic                       arready,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    // AXI read data
    input  logic                       rvalid,
    input  logic [31:0]                rdata,
    input  logic                       rlast,
    output logic                       rready,
    // AXI write address
    output logic                       awvalid,
    input  logic                       awready,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    // AXI write data
    output logic                       wvalid,
    input  logic                       wready,
    output logic [31:0]                wdata,
    output logic                       wlast,
    // AXI write response
    input  logic                       bvalid,
    input  logic [1:0]                 bresp,
    output logic                       bready
);

    localparam int unsigned CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned OFS = $clog2(LINE_WORDS * 4);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFS) - 32'd1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WAw, WData, WResp} w_state_e;

    r_state_e                  r_state_q;
    logic                      r_idle_q;
    logic [31:0]               r_addr_q;

    w_state_e                  w_state_q;
    logic                      w_idle_q;
    logic [31:0]               w_addr_q;
    logic [LINE_WORDS*32-1:0]  w_line_q;
    logic [CW-1:0]             beat_q;

    // Only bresp[1] distinguishes error responses.
    logic unused_bresp;
    assign unused_bresp = bresp[0];

    // ---------------------------------------------------------------- read path
`ifdef RAW_HAZARD_CHECK_EN
    logic [31:0] rd_line;
    logic        raw_hazard;
    assign rd_line = rd_addr & ALIGN_MASK;
    // Also covers a writeback of the same line being accepted in this very cycle.
    assign raw_hazard = (!w_idle_q && (rd_line == w_addr_q)) ||
                        (w_idle_q && wr_req && (rd_line == (wr_addr & ALIGN_MASK)));
    assign rd_rdy = r_idle_q && !raw_hazard;
`else
    assign rd_rdy = r_idle_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= RIdle;
            r_idle_q  <= 1'b1;
            r_addr_q  <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    if (rd_req && rd_rdy) begin
                        r_state_q <= RAddr;
                        r_idle_q  <= 1'b0;
                        r_addr_q  <= rd_addr & ALIGN_MASK;
                        arvalid   <= 1'b1;
                    end
                end
                RAddr: begin
                    if (arready) begin
                        r_state_q <= RData;
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                    end
                end
                RData: begin
                    if (rvalid && rlast) begin
                        r_state_q <= RIdle;
                        r_idle_q  <= 1'b1;
                        rready    <= 1'b0;
                    end
                end
                default: begin
                    r_state_q <= RIdle;
                    r_idle_q  <= 1'b1;
                    arvalid   <= 1'b0;
                    rready    <= 1'b0;
                end
            endcase
        end
    end

    assign araddr    = r_addr_q;
    assign arlen     = 8'(LINE_WORDS - 1);
    assign ret_valid = rvalid & rready;
    assign ret_data  = rdata;
    assign ret_last  = rlast;

    // --------------------------------------------------------------- write path
    assign wr_rdy = w_idle_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= WIdle;
            w_idle_q  <= 1'b1;
            w_addr_q  <= '0;
            w_line_q  <= '0;
            beat_q    <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    if (wr_req && w_idle_q) begin
                        w_state_q <= WAw;
                        w_idle_q  <= 1'b0;
                        w_addr_q  <= wr_addr & ALIGN_MASK;
                        w_line_q  <= wr_data;
                        awvalid   <= 1'b1;
                    end
                end
                WAw: begin
                    if (awready) begin
                        w_state_q <= WData;
                        awvalid   <= 1'b0;
                        wvalid    <= 1'b1;
                        beat_q    <= '0;
                    end
                end
                WData: begin
                    if (wready) begin
                        if (beat_q == LAST_BEAT) begin
                            w_state_q <= WResp;
                            wvalid    <= 1'b0;
                            bready    <= 1'b1;
                            beat_q    <= '0;
                        end else begin
                            beat_q <= beat_q + CW'(1);
                        end
                    end
                end
                WResp: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp[1]) begin
                            // Error response: replay the whole line from the latched copy.
                            w_state_q <= WAw;
                            awvalid   <= 1'b1;
                        end else begin
                            w_state_q <= WIdle;
                            w_idle_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_q <= WIdle;
                    w_idle_q  <= 1'b1;
                    awvalid   <= 1'b0;
                    wvalid    <= 1'b0;
                    bready    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wdata = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (beat_q == CW'(i)) begin
                wdata = w_line_q[i*32 +: 32];
            end
        end
    end

    assign wlast  = (beat_q == LAST_BEAT);
    assign awaddr = w_addr_q;
    assign awlen  = 8'(LINE_WORDS - 1);

endmodule

// File: tb/tb_cache_axi_burst_if.sv
// Directed bench for cache_axi_burst_if: refill, writeback, error replay, RAW check, reset.
// Instances with LINE_WORDS = 4 (main), 1 and 16 (writeback/reset only).
module tb_cache_axi_burst_if;

    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic           rd_req = 0, rd_rdy, ret_valid, ret_last;
    logic [31:0]    rd_addr = 0, ret_data;
    logic           wr_req = 0, wr_rdy;
    logic [31:0]    wr_addr = 0;
    logic [LW*32-1:0] wr_data = 0;
    logic           arvalid, arready = 0, rvalid = 0, rlast = 0, rready;
    logic [31:0]    araddr, rdata = 0;
    logic [7:0]     arlen, awlen;
    logic           awvalid, awready = 0, wvalid, wready = 0, wlast, bvalid = 0, bready;
    logic [31:0]    awaddr, wdata;
    logic [1:0]     bresp = 0;

    // shared stimulus for the auxiliary instances
    logic           x_wr_req = 0, x_awready = 0, x_wready = 0, x_bvalid = 0;
    logic [31:0]    x_wr_addr = 0;
    logic [1:0]     x_bresp = 0;
    logic           x_zero = 0;
    logic [31:0]    x_zero32 = 0;
    logic [31:0]    x1_data = 0;
    logic [511:0]   x16_data = 0;

    logic        x1_wr_rdy, x1_awvalid, x1_wvalid, x1_wlast, x1_bready;
    logic [31:0] x1_wdata, x1_awaddr;
    logic [7:0]  x1_awlen;
    logic        x1_rd_rdy, x1_ret_valid, x1_ret_last, x1_arvalid, x1_rready;
    logic [31:0] x1_ret_data, x1_araddr;
    logic [7:0]  x1_arlen;

    logic        x16_wr_rdy, x16_awvalid, x16_wvalid, x16_wlast, x16_bready;
    logic [31:0] x16_wdata, x16_awaddr;
    logic [7:0]  x16_awlen;
    logic        x16_rd_rdy, x16_ret_valid, x16_ret_last, x16_arvalid, x16_rready;
    logic [31:0] x16_ret_data, x16_araddr;
    logic [7:0]  x16_arlen;

    cache_axi_burst_if #(.LINE_WORDS(LW)) u_dut4 (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    cache_axi_burst_if #(.LINE_WORDS(1)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .rd_req(x_zero), .rd_addr(x_zero32), .rd_rdy(x1_rd_rdy),
        .ret_valid(x1_ret_valid), .ret_last(x1_ret_last), .ret_data(x1_ret_data),
        .wr_req(x_wr_req), .wr_addr(x_wr_addr), .wr_data(x1_data), .wr_rdy(x1_wr_rdy),
        .arvalid(x1_arvalid), .arready(x_zero), .araddr(x1_araddr), .arlen(x1_arlen),
        .rvalid(x_zero), .rdata(x_zero32), .rlast(x_zero), .rready(x1_rready),
        .awvalid(x1_awvalid), .awready(x_awready), .awaddr(x1_awaddr), .awlen(x1_awlen),
        .wvalid(x1_wvalid), .wready(x_wready), .wdata(x1_wdata), .wlast(x1_wlast),
        .bvalid(x_bvalid), .bresp(x_bresp), .bready(x1_bready)
    );

    cache_axi_burst_if #(.LINE_WORDS(16)) u_dut16 (
        .clk(clk), .resetn(resetn),
        .rd_req(x_zero), .rd_addr(x_zero32), .rd_rdy(x16_rd_rdy),
        .ret_valid(x16_ret_valid), .ret_last(x16_ret_last), .ret_data(x16_ret_data),
        .wr_req(x_wr_req), .wr_addr(x_wr_addr), .wr_data(x16_data), .wr_rdy(x16_wr_rdy),
        .arvalid(x16_arvalid), .arready(x_zero), .araddr(x16_araddr), .arlen(x16_arlen),
        .rvalid(x_zero), .rdata(x_zero32), .rlast(x_zero), .rready(x16_rready),
        .awvalid(x16_awvalid), .awready(x_awready), .awaddr(x16_awaddr), .awlen(x16_awlen),
        .wvalid(x16_wvalid), .wready(x_wready), .wdata(x16_wdata), .wlast(x16_wlast),
        .bvalid(x_bvalid), .bresp(x_bresp), .bready(x16_bready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = base + 32'(i) * 32'h0101;
        return l;
    endfunction

    function automatic logic [511:0] mk_line16(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i) * 32'h0011;
        return l;
    endfunction

    // Called in R_ADDR just after a negedge.
    task automatic finish_read(input logic [31:0] exp_addr, input int ar_wait,
                               input logic [31:0] base);
        for (int k = 0; k < ar_wait; k++) begin
            check_eq("rd arvalid held", arvalid, 1'b1);
            check_eq("rd araddr held", araddr, exp_addr);
            tick();
            #1;
        end
        check_eq("rd arvalid", arvalid, 1'b1);
        check_eq("rd araddr", araddr, exp_addr);
        check_eq("rd arlen", arlen, 8'd3);
        arready = 1;
        tick();
        arready = 0;
        #1;
        check_eq("rd arvalid drop", arvalid, 1'b0);
        check_eq("rd rready", rready, 1'b1);
        for (int i = 0; i < LW; i++) begin
            rvalid = 1;
            rdata = base + 32'(i);
            rlast = (i == LW - 1);
            #1;
            check_eq($sformatf("ret_valid b%0d", i), ret_valid, 1'b1);
            check_eq($sformatf("ret_data b%0d", i), ret_data, base + 32'(i));
            check_eq($sformatf("ret_last b%0d", i), ret_last, (i == LW - 1));
            tick();
        end
        rvalid = 0;
        rlast = 0;
        #1;
        check_eq("rd_rdy back", rd_rdy, 1'b1);
        check_eq("rready drop", rready, 1'b0);
    endtask

    // Called in W_AW just after a negedge; stops in W_RESP.
    task automatic wr_burst(input logic [31:0] exp_addr, input logic [127:0] line,
                            input bit toggle);
        int beat = 0;
        bit acc;
        check_eq("wr awvalid", awvalid, 1'b1);
        check_eq("wr awaddr", awaddr, exp_addr);
        check_eq("wr awlen", awlen, 8'd3);
        check_eq("wr_rdy busy", wr_rdy, 1'b0);
        awready = 1;
        tick();
        awready = 0;
        for (int cyc = 0; cyc < 24 && beat < LW; cyc++) begin
            wready = toggle ? (cyc % 2 == 0) : 1'b1;
            acc = wready;
            #1;
            check_eq($sformatf("wvalid b%0d", beat), wvalid, 1'b1);
            check_eq($sformatf("wdata b%0d", beat), wdata, line[beat*32 +: 32]);
            check_eq($sformatf("wlast b%0d", beat), wlast, (beat == LW - 1));
            tick();
            if (acc) beat++;
        end
        wready = 0;
        check_eq("wr beats", beat, LW);
        #1;
        check_eq("wvalid drop", wvalid, 1'b0);
        check_eq("bready", bready, 1'b1);
    endtask

    task automatic wr_resp(input logic [1:0] resp, input int wait_cyc);
        for (int k = 0; k < wait_cyc; k++) begin
            check_eq("bready wait", bready, 1'b1);
            tick();
            #1;
        end
        bvalid = 1;
        bresp = resp;
        tick();
        bvalid = 0;
        bresp = 0;
        #1;
    endtask

    task automatic run_aux(input logic [31:0] w1, input logic [511:0] l16, input int rst_at,
                           input logic [31:0] a);
        int c1 = 0;
        int c16 = 0;
        bit rst_done = 0;
        x_wr_req = 1; x_wr_addr = a; x1_data = w1; x16_data = l16;
        x_awready = 1; x_wready = 1; x_bvalid = 1; x_bresp = 0;
        tick();
        x_wr_req = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            if (rst_at >= 0 && c16 == rst_at) begin
                check_eq("aux16 mid burst", x16_wvalid, 1'b1);
                resetn = 0;
                #1;
                check_eq("aux16 rst wvalid", x16_wvalid, 1'b0);
                check_eq("aux16 rst awvalid", x16_awvalid, 1'b0);
                check_eq("aux16 rst bready", x16_bready, 1'b0);
                check_eq("aux16 rst wr_rdy", x16_wr_rdy, 1'b1);
                @(negedge clk);
                resetn = 1;
                rst_done = 1;
                break;
            end
            if (x1_wvalid) begin
                check_eq("aux1 wdata", x1_wdata, w1);
                check_eq("aux1 wlast", x1_wlast, 1'b1);
                c1++;
            end
            if (x16_wvalid) begin
                check_eq($sformatf("aux16 wdata b%0d", c16), x16_wdata, l16[c16*32 +: 32]);
                check_eq($sformatf("aux16 wlast b%0d", c16), x16_wlast, (c16 == 15));
                c16++;
            end
            if (c1 >= 1 && c16 >= 16 && x1_wr_rdy && x16_wr_rdy) break;
            tick();
        end
        x_bvalid = 0; x_awready = 0; x_wready = 0;
        if (rst_at >= 0) begin
            check_eq("aux reset reached", rst_done, 1'b1);
        end else begin
            check_eq("aux1 beat count", c1, 1);
            check_eq("aux16 beat count", c16, 16);
            check_eq("aux16 awlen", x16_awlen, 8'd15);
            check_eq("aux1 awaddr", x1_awaddr, a & 32'hFFFF_FFFC);
            check_eq("aux16 awaddr", x16_awaddr, a & 32'hFFFF_FFC0);
        end
    endtask

    initial begin
        logic [127:0] l;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst rd_rdy", rd_rdy, 1'b1);
        check_eq("rst wr_rdy", wr_rdy, 1'b1);
        check_eq("rst arvalid", arvalid, 1'b0);
        check_eq("rst awvalid", awvalid, 1'b0);
        check_eq("rst wvalid", wvalid, 1'b0);
        check_eq("rst rready", rready, 1'b0);
        check_eq("rst bready", bready, 1'b0);
        check_eq("rst awaddr", awaddr, 32'h0);
        resetn = 1;

        // line refill, address misaligned within the line
        rd_req = 1; rd_addr = 32'h1C00_0014;
        #1;
        check_eq("rd_rdy idle", rd_rdy, 1'b1);
        tick();
        rd_req = 0;
        #1;
        check_eq("rd_rdy busy", rd_rdy, 1'b0);
        finish_read(32'h1C00_0010, 2, 32'hCAFE_0000);

        // writeback with wready toggling
        l = mk_line(32'hD000_0000);
        wr_req = 1; wr_addr = 32'h0000_0100; wr_data = l;
        #1;
        check_eq("wr_rdy idle", wr_rdy, 1'b1);
        tick();
        wr_req = 0;
        #1;
        wr_burst(32'h0000_0100, l, 1);
        wr_resp(2'b00, 2);
        check_eq("wr done wr_rdy", wr_rdy, 1'b1);
        check_eq("wr done bready", bready, 1'b0);

        // error response replays the burst
        l = mk_line(32'hE000_0000);
        wr_req = 1; wr_addr = 32'h0000_0204; wr_data = l;
        tick();
        wr_req = 0; wr_data = 0;
        #1;
        wr_burst(32'h0000_0200, l, 0);
        wr_resp(2'b10, 0);
        check_eq("replay awvalid", awvalid, 1'b1);
        check_eq("replay wr_rdy", wr_rdy, 1'b0);
        check_eq("replay bready", bready, 1'b0);
        wr_burst(32'h0000_0200, l, 1);
        wr_resp(2'b00, 0);
        check_eq("replay done wr_rdy", wr_rdy, 1'b1);

        // simultaneous refill and writeback of the same line
        l = mk_line(32'h8800_0000);
        rd_req = 1; rd_addr = 32'h80;
        wr_req = 1; wr_addr = 32'h80; wr_data = l;
        tick();
        wr_req = 0;
        #1;
        check_eq("same wr accepted", awvalid, 1'b1);
`ifdef RAW_HAZARD_CHECK_EN
        check_eq("raw arvalid held off", arvalid, 1'b0);
        check_eq("raw rd_rdy low", rd_rdy, 1'b0);
        wr_burst(32'h80, l, 0);
        check_eq("raw arvalid in resp", arvalid, 1'b0);
        wr_resp(2'b00, 1);
        check_eq("raw arvalid after b", arvalid, 1'b0);
        check_eq("raw rd_rdy after b", rd_rdy, 1'b1);
        tick();
        rd_req = 0;
        #1;
        finish_read(32'h80, 0, 32'h5A5A_0000);
`else
        check_eq("no raw arvalid", arvalid, 1'b1);
        rd_req = 0;
        finish_read(32'h80, 0, 32'h5A5A_0000);
        wr_burst(32'h80, l, 0);
        wr_resp(2'b00, 0);
`endif
        check_eq("same done wr_rdy", wr_rdy, 1'b1);

        // asynchronous reset during write beat 2
        l = mk_line(32'hF000_0000);
        wr_req = 1; wr_addr = 32'h300; wr_data = l;
        tick();
        wr_req = 0;
        #1;
        check_eq("rst-w awvalid", awvalid, 1'b1);
        awready = 1;
        tick();
        awready = 0; wready = 1;
        tick();
        tick();
        #1;
        check_eq("rst-w beat2 data", wdata, l[95:64]);
        #2;
        resetn = 0;
        #1;
        check_eq("arst awvalid", awvalid, 1'b0);
        check_eq("arst wvalid", wvalid, 1'b0);
        check_eq("arst bready", bready, 1'b0);
        check_eq("arst wr_rdy", wr_rdy, 1'b1);
        check_eq("arst rd_rdy", rd_rdy, 1'b1);
        check_eq("arst arvalid", arvalid, 1'b0);
        check_eq("arst rready", rready, 1'b0);
        wready = 0;
        @(negedge clk);
        resetn = 1;
        l = mk_line(32'hA500_0000);
        wr_req = 1; wr_addr = 32'h340; wr_data = l;
        #1;
        check_eq("post-rst wr_rdy", wr_rdy, 1'b1);
        tick();
        wr_req = 0;
        #1;
        wr_burst(32'h340, l, 0);
        wr_resp(2'b00, 0);

        // LINE_WORDS = 1 and 16
        run_aux(32'h1234_5678, mk_line16(32'h6000_0000), -1, 32'h0000_0447);
        run_aux(32'h8765_4321, mk_line16(32'h7000_0000), 2, 32'h0000_0880);
        run_aux(32'h0BAD_F00D, mk_line16(32'h9000_0000), -1, 32'h0000_0C0C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
